// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: VGA scan-out reads, a full-screen clear engine and
// a buffered pixel-write FIFO share one synchronous single-port RAM.
module fb_arbiter #(
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int SCALE_SHIFT = 2,
   parameter int ADDR_W      = 15,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              pix_ce,
   input  logic              vga_active,
   input  logic [9:0]        vga_rx,
   input  logic [9:0]        vga_ry,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [7:0]        wr_x,
   input  logic [6:0]        wr_y,
   input  logic [5:0]        wr_color,
   input  logic              clr_start,
   input  logic [5:0]        clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [5:0]        mem_wdata,
   input  logic [5:0]        mem_rdata,
   output logic [1:0]        pix_r,
   output logic [1:0]        pix_g,
   output logic [1:0]        pix_b,
   output logic              frame_tick
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] FB_W_A  = ADDR_W'(FB_W);
   localparam logic [ADDR_W-1:0] FB_H_A  = ADDR_W'(FB_H);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(FB_W * FB_H - 1);
   localparam logic [9:0]        FB_W_S  = 10'(FB_W);
   localparam logic [9:0]        FB_H_S  = 10'(FB_H);
   localparam logic [PTR_W:0]    DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} clr_state_t;

   clr_state_t        state_q;
   logic [ADDR_W-1:0] clr_cnt_q;
   logic [5:0]        clr_col_q;
   logic              clr_busy_q;
   logic              clr_done_q;

   logic              alive_q;
   logic [ADDR_W-1:0] addr_q;
   logic [5:0]        wdata_q;
   logic              ce1_q;
   logic              rd1_q;
   logic [5:0]        pix_q;
   logic              frame_tick_q;

   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [5:0]        fifo_col_q  [FIFO_DEPTH];
   logic              fifo_ok_q   [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W:0]    count_q;

   logic [9:0]        fx_s;
   logic [9:0]        fy_s;
   logic              disp_rd_s;
   logic [ADDR_W-1:0] disp_addr_s;
   logic              clr_wr_s;
   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              pop_s;
   logic              fifo_we_s;
   logic [ADDR_W-1:0] push_addr_s;
   logic              push_ok_s;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [5:0]        mem_wdata_s;

   assign fx_s        = vga_rx >> SCALE_SHIFT;
   assign fy_s        = vga_ry >> SCALE_SHIFT;
   assign disp_rd_s   = alive_q && pix_ce && vga_active && (fx_s < FB_W_S) && (fy_s < FB_H_S);
   assign disp_addr_s = ADDR_W'(fy_s) * FB_W_A + ADDR_W'(fx_s);

   assign full_s      = (count_q == DEPTH_C);
   assign empty_s     = (count_q == '0);
   assign wr_ready    = alive_q && !full_s;
   assign push_s      = wr_valid && wr_ready;
   assign push_addr_s = ADDR_W'(wr_y) * FB_W_A + ADDR_W'(wr_x);
   assign push_ok_s   = (ADDR_W'(wr_x) < FB_W_A) && (ADDR_W'(wr_y) < FB_H_A);

   // A pending clr_start also holds the FIFO so queued pixels land on top of the clear.
   assign clr_wr_s  = (state_q == S_CLEAR) && !disp_rd_s;
   assign pop_s     = alive_q && !empty_s && (state_q == S_IDLE) && !clr_start && !disp_rd_s;
   assign fifo_we_s = pop_s && fifo_ok_q[rd_ptr_q];

   // RAM port mux: display read, then clear write, then FIFO write; idle holds the address.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = addr_q;
      mem_wdata_s = wdata_q;
      if (disp_rd_s) begin
         mem_addr_s = disp_addr_s;
      end else if (clr_wr_s) begin
         mem_we_s    = 1'b1;
         mem_addr_s  = clr_cnt_q;
         mem_wdata_s = clr_col_q;
      end else if (fifo_we_s) begin
         mem_we_s    = 1'b1;
         mem_addr_s  = fifo_addr_q[rd_ptr_q];
         mem_wdata_s = fifo_col_q[rd_ptr_q];
      end else begin
         mem_we_s = 1'b0;
      end
   end

   assign mem_we    = mem_we_s;
   assign mem_addr  = mem_addr_s;
   assign mem_wdata = mem_wdata_s;

   // Port hold registers, display pipeline and frame tick.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         alive_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 6'd0;
         ce1_q        <= 1'b0;
         rd1_q        <= 1'b0;
         pix_q        <= 6'd0;
         frame_tick_q <= 1'b0;
      end else begin
         alive_q      <= 1'b1;
         addr_q       <= mem_addr_s;
         wdata_q      <= mem_wdata_s;
         ce1_q        <= alive_q && pix_ce;
         rd1_q        <= disp_rd_s;
         frame_tick_q <= alive_q && pix_ce && vga_active && (vga_rx == 10'd0) && (vga_ry == 10'd0);
         if (ce1_q) begin
            pix_q <= rd1_q ? mem_rdata : 6'd0;
         end
      end
   end

   assign pix_r      = pix_q[5:4];
   assign pix_g      = pix_q[3:2];
   assign pix_b      = pix_q[1:0];
   assign frame_tick = frame_tick_q;

   // Write FIFO pointers and occupancy.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage; contents are don't-care while the entry is not occupied.
   always_ff @(posedge CLOCK_50) begin
      if (push_s) begin
         fifo_addr_q[wr_ptr_q] <= push_addr_s;
         fifo_col_q[wr_ptr_q]  <= wr_color;
         fifo_ok_q[wr_ptr_q]   <= push_ok_s;
      end
   end

   // Clear engine: walks every framebuffer address, yielding to display reads.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         clr_cnt_q  <= '0;
         clr_col_q  <= 6'd0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         clr_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (clr_start) begin
                  state_q    <= S_CLEAR;
                  clr_cnt_q  <= '0;
                  clr_col_q  <= clr_color;
                  clr_busy_q <= 1'b1;
               end
            end
            S_CLEAR: begin
               if (clr_wr_s) begin
                  if (clr_cnt_q == LAST_A) begin
                     state_q    <= S_IDLE;
                     clr_busy_q <= 1'b0;
                     clr_done_q <= 1'b1;
                  end else begin
                     clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                  end
               end
            end
            default: begin
               state_q    <= S_IDLE;
               clr_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign clr_busy = clr_busy_q;
   assign clr_done = clr_done_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: RAM model plus a cycle-level reference of
// the arbitration rules, driven by directed steps and a randomized phase.
`timescale 1ns/1ps
module tb_fb_arbiter;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        pix_ce, vga_active;
   logic [9:0]  vga_rx, vga_ry;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_x;
   logic [6:0]  wr_y;
   logic [5:0]  wr_color;
   logic        clr_start, clr_busy, clr_done;
   logic [5:0]  clr_color;
   logic [14:0] mem_addr;
   logic        mem_we;
   logic [5:0]  mem_wdata;
   logic [5:0]  mem_rdata = 6'd0;
   logic [1:0]  pix_r, pix_g, pix_b;
   logic        frame_tick;

   fb_arbiter dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .pix_ce(pix_ce), .vga_active(vga_active),
      .vga_rx(vga_rx), .vga_ry(vga_ry), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .clr_start(clr_start),
      .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .frame_tick(frame_tick)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   logic [5:0] ram [0:32767];

   always @(posedge CLOCK_50) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        ok;
      logic [31:0] addr;
      logic [5:0]  col;
   } ent_t;

   ent_t       m_q[$];
   bit         m_alive, m_clr, m_done, m_ft, s1_ce, last_push;
   int         m_cnt, m_addr;
   logic [5:0] m_col, m_pix, s1_val;
   int         dut_done_cnt, dut_busy_we;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      pix_ce = 1'b0; vga_active = 1'b0; vga_rx = 10'd1023; vga_ry = 10'd1023;
      wr_valid = 1'b0; wr_x = 8'd0; wr_y = 7'd0; wr_color = 6'd0;
      clr_start = 1'b0; clr_color = 6'd0;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_alive = 1'b0; m_clr = 1'b0; m_done = 1'b0; m_ft = 1'b0; s1_ce = 1'b0;
      m_cnt = 0; m_addr = 0; m_col = 6'd0; m_pix = 6'd0; s1_val = 6'd0;
   endtask

   // Asserts reset mid-cycle, checks the immediate output state, then releases.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_pix", {pix_r, pix_g, pix_b}, 0);
      chk("rst_frame_tick", frame_tick, 0);
      chk("rst_clr_busy", clr_busy, 0);
      chk("rst_clr_done", clr_done, 0);
      chk("rst_wr_ready", wr_ready, 0);
      model_reset();
      set_idle();
      repeat (2) @(posedge CLOCK_50);
      #1;
      reset = 1'b0;
   endtask

   // One clock cycle: predict every output from the current inputs, compare, advance.
   task automatic cyc();
      bit disp, we_e, ready_e, clr_n, done_n, ft_n, pce;
      int fx, fy, daddr, addr_e, cnt_n;
      logic [5:0] data_e, pv;
      ent_t e;
      #3;
      fx      = int'(vga_rx) / 4;
      fy      = int'(vga_ry) / 4;
      disp    = m_alive && pix_ce && vga_active && fx < 160 && fy < 120;
      daddr   = (fy * 160 + fx) % 32768;
      ready_e = m_alive && (m_q.size() < 4);
      chk("wr_ready", wr_ready, ready_e);
      chk("clr_busy", clr_busy, m_clr);
      chk("clr_done", clr_done, m_done);
      chk("pix", {pix_r, pix_g, pix_b}, m_pix);
      chk("frame_tick", frame_tick, m_ft);
      if (clr_done) dut_done_cnt++;
      if (clr_busy && mem_we) dut_busy_we++;
      we_e = 1'b0; addr_e = m_addr; data_e = 6'd0;
      clr_n = m_clr; cnt_n = m_cnt; done_n = 1'b0;
      if (disp) begin
         addr_e = daddr;
      end else if (m_clr) begin
         we_e = 1'b1; addr_e = m_cnt; data_e = m_col;
         if (m_cnt == 160 * 120 - 1) begin clr_n = 1'b0; done_n = 1'b1; end
         else cnt_n = m_cnt + 1;
      end else if (m_q.size() > 0 && !clr_start) begin
         e = m_q.pop_front();
         if (e.ok) begin we_e = 1'b1; addr_e = int'(e.addr); data_e = e.col; end
      end
      if (!m_clr && clr_start) begin clr_n = 1'b1; cnt_n = 0; m_col = clr_color; end
      chk("mem_we", mem_we, we_e);
      chk("mem_addr", mem_addr, addr_e);
      if (we_e) chk("mem_wdata", mem_wdata, data_e);
      last_push = wr_valid && ready_e;
      if (last_push) begin
         e.ok   = (wr_x < 160) && (wr_y < 120);
         e.addr = (int'(wr_y) * 160 + int'(wr_x)) % 32768;
         e.col  = wr_color;
         m_q.push_back(e);
      end
      pce  = m_alive && pix_ce;
      pv   = disp ? ram[daddr] : 6'd0;
      ft_n = m_alive && pix_ce && vga_active && vga_rx == 10'd0 && vga_ry == 10'd0;
      @(posedge CLOCK_50);
      #1;
      if (s1_ce) m_pix = s1_val;
      s1_ce = pce; s1_val = pv;
      m_ft = ft_n; m_clr = clr_n; m_cnt = cnt_n; m_done = done_n;
      m_addr = addr_e; m_alive = 1'b1;
   endtask

   logic [7:0] tx [5];
   logic [6:0] ty [5];
   int acc;

   initial begin
      for (int i = 0; i < 32768; i++) ram[i] = 6'($urandom);
      ram[321] = 6'b110110;
      set_idle();
      model_reset();
      #1;
      do_reset();

      // Single display read at rx=4, ry=8.
      cyc();
      pix_ce = 1'b1; vga_active = 1'b1; vga_rx = 10'd4; vga_ry = 10'd8;
      cyc();
      set_idle();
      cyc();
      cyc();
      chk("t1_pix", {pix_r, pix_g, pix_b}, 6'b110110);

      // Five back-to-back writes while display traffic stalls the FIFO.
      tx[0] = 8'd10; ty[0] = 7'd3;  tx[1] = 8'd20; ty[1] = 7'd4;
      tx[2] = 8'd30; ty[2] = 7'd5;  tx[3] = 8'd40; ty[3] = 7'd6;
      tx[4] = 8'd50; ty[4] = 7'd7;
      acc = 0;
      for (int i = 0; i < 20; i++) begin
         pix_ce = (i < 7); vga_active = 1'b1;
         vga_rx = 10'($urandom_range(0, 639)); vga_ry = 10'($urandom_range(0, 479));
         wr_valid = (acc < 5);
         if (acc < 5) begin wr_x = tx[acc]; wr_y = ty[acc]; wr_color = 6'(acc + 9); end
         cyc();
         if (last_push) acc++;
      end
      chk("five_accepted", acc, 5);
      set_idle();

      // Full clear with a valid and an out-of-range write queued mid-clear.
      dut_done_cnt = 0; dut_busy_we = 0;
      clr_start = 1'b1; clr_color = 6'h3F;
      cyc();
      set_idle();
      for (int i = 0; i < 19250; i++) begin
         if (i == 5000) begin wr_valid = 1'b1; wr_x = 8'd7; wr_y = 7'd7; wr_color = 6'h15; end
         else if (i == 6000) begin wr_valid = 1'b1; wr_x = 8'd200; wr_y = 7'd5; wr_color = 6'h2A; end
         else wr_valid = 1'b0;
         cyc();
      end
      chk("clr_done_count", dut_done_cnt, 1);
      chk("clr_busy_writes", dut_busy_we, 19200);
      chk("queued_write_ram", ram[7 * 160 + 7], 6'h15);

      // Reset in the middle of a second clear.
      dut_done_cnt = 0;
      clr_start = 1'b1; clr_color = 6'h2A;
      cyc();
      clr_start = 1'b0;
      for (int i = 0; i < 200 && m_cnt != 100; i++) cyc();
      chk("clr_reached_100", m_cnt, 100);
      do_reset();
      cyc();
      cyc();
      chk("no_done_after_abort", dut_done_cnt, 0);
      pix_ce = 1'b1; vga_active = 1'b1; vga_rx = 10'd0; vga_ry = 10'd0;
      cyc();
      set_idle();
      chk("frame_tick_pulse", frame_tick, 1);
      cyc();
      cyc();

      // Randomized traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         pix_ce     = ($urandom % 3) == 0;
         vga_active = ($urandom % 4) != 0;
         vga_rx     = vga_active ? 10'($urandom_range(0, 700)) : 10'd1023;
         vga_ry     = vga_active ? 10'($urandom_range(0, 479)) : 10'd1023;
         if (($urandom % 50) == 0) begin vga_rx = 10'd0; vga_ry = 10'd0; end
         wr_valid   = ($urandom % 2) == 1;
         wr_x       = 8'($urandom_range(0, 180));
         wr_y       = 7'($urandom_range(0, 127));
         wr_color   = 6'($urandom);
         cyc();
      end
      set_idle();
      repeat (10) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
